vga_line_fetch_ctrl: RTL and testbench

Schedules framebuffer reads for the vga timing generator and shares the single-port framebuffer RAM between display fetch and a pixel-writer requester. For each upcoming visible line it fetches H_ACTIVE words into a ping-pong line buffer, one bank per line, while the scan-out side reads the other bank. It sits between the vga block (h_count/v_count, pixel enable), the framebuffer RAM and the line-buffer RAM.

---
 rtl/vga_line_fetch_ctrl_pkg.sv | 28 ++
 rtl/vga_line_fetch_ctrl_if.sv | 40 ++++
 rtl/vga_rd_return_pipe.sv | 39 +++
 rtl/vga_line_fetch_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_vga_line_fetch_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_line_fetch_ctrl_pkg.sv
// Shared vga definitions: timing constants, fetch FSM encoding and the
// read-return tag carried alongside framebuffer reads.
package vga_line_fetch_ctrl_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_V_TOTAL  = 525;

  localparam int LB_ADDR_W = 10;
  localparam int CNT_W     = 12;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic                 valid;
    logic [LB_ADDR_W-1:0] x;
  } rd_tag_t;

  // Line that will be displayed after the current one, wrapping at frame end.
  function automatic logic [CNT_W-1:0] next_line_of(input logic [CNT_W-1:0] v,
                                                    input int v_total);
    return (v == CNT_W'(v_total - 1)) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_line_fetch_ctrl_if.sv
// Framebuffer RAM port and pixel-writer request port used by the line
// fetch controller.
interface vga_fb_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 24
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

interface vga_wr_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 24
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output wr_valid, wr_addr, wr_data,
    input  wr_ready
  );
  modport slave (
    input  wr_valid, wr_addr, wr_data,
    output wr_ready
  );
endinterface

// File: rtl/vga_rd_return_pipe.sv
// Valid/x-index shift register that tracks outstanding framebuffer reads
// until their data arrives; flush drops everything in flight.
module vga_rd_return_pipe
  import vga_line_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  input  rd_tag_t in_tag,
  output rd_tag_t out_tag
);

  rd_tag_t chain [DEPTH+1];

  assign chain[0] = in_tag;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      rd_tag_t stage_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_reg <= '0;
        end else if (flush) begin
          stage_reg <= '0;
        end else begin
          stage_reg <= chain[gi];
        end
      end

      assign chain[gi+1] = stage_reg;
    end
  endgenerate

  assign out_tag = chain[DEPTH];

endmodule

// File: rtl/vga_line_fetch_ctrl.sv
// Fetches each upcoming visible line into a ping-pong line buffer and
// shares the single-port framebuffer with a pixel-writer requester.
module vga_line_fetch_ctrl
  import vga_line_fetch_ctrl_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_TOTAL  = VGA_V_TOTAL,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 24,
  parameter int RD_LAT   = 2,
  parameter int WR_SHARE = 4
) (
  input  logic                 board_clock,
  input  logic                 reset_n,
  input  logic                 pix_ce,
  input  logic [CNT_W-1:0]     h_count,
  input  logic [CNT_W-1:0]     v_count,
  vga_wr_if.slave              wr,
  vga_fb_if.master             fb,
  output logic                 lb_we,
  output logic                 lb_bank,
  output logic [LB_ADDR_W-1:0] lb_addr,
  output logic [DATA_W-1:0]    lb_wdata,
  output logic                 disp_bank,
  output logic                 fetch_busy,
  output logic                 underrun
);

  localparam int SHARE_W = (WR_SHARE > 1) ? $clog2(WR_SHARE) : 1;
  localparam int DRAIN_W = $clog2(RD_LAT + 1);

  logic [1:0]           state_reg, state_next;
  logic [LB_ADDR_W-1:0] x_issue_reg;
  logic [ADDR_W-1:0]    line_base_reg;
  logic [SHARE_W-1:0]   share_cnt_reg;
  logic [DRAIN_W-1:0]   drain_cnt_reg;
  logic                 disp_bank_reg;
  logic                 lb_bank_reg;
  logic                 underrun_reg;
  logic                 run_reg;
  logic                 mem_req_reg;
  logic                 mem_we_reg;
  logic [ADDR_W-1:0]    mem_addr_reg;
  logic [DATA_W-1:0]    mem_wdata_reg;

  logic             ls;
  logic [CNT_W-1:0] next_line;
  logic             start;
  logic             busy;
  logic             abort;
  logic             slot;
  logic             wr_ready_c;
  logic             wr_fire;
  logic             issue;
  logic             last_issue;
  rd_tag_t          pipe_in;
  rd_tag_t          pipe_out;

  assign ls        = pix_ce && (h_count == '0);
  assign next_line = next_line_of(v_count, V_TOTAL);
  assign start     = ls && (next_line < CNT_W'(V_ACTIVE));
  assign busy      = (state_reg == ST_FETCH) || (state_reg == ST_DRAIN);
  assign abort     = ls && busy;
  assign slot      = (share_cnt_reg == SHARE_W'(WR_SHARE - 1));

  // run_reg keeps wr_ready low while reset is held and on the first cycle after.
  assign wr_ready_c = run_reg && !start &&
                      ((state_reg == ST_IDLE) || (state_reg == ST_DRAIN) ||
                       ((state_reg == ST_FETCH) && slot));
  assign wr_fire    = wr.wr_valid && wr_ready_c;

  // A line start always preempts the fetch cycle it lands on.
  assign issue      = (state_reg == ST_FETCH) && !ls && !(slot && wr.wr_valid);
  assign last_issue = issue && (x_issue_reg == LB_ADDR_W'(H_ACTIVE - 1));

  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = ST_FETCH;
    end else if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_FETCH: if (last_issue) state_next = ST_DRAIN;
        ST_DRAIN: if (drain_cnt_reg == DRAIN_W'(RD_LAT - 1)) state_next = ST_IDLE;
        default:  state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge board_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      x_issue_reg   <= '0;
      line_base_reg <= '0;
      share_cnt_reg <= '0;
      drain_cnt_reg <= '0;
      disp_bank_reg <= 1'b0;
      lb_bank_reg   <= 1'b0;
      underrun_reg  <= 1'b0;
      run_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      run_reg   <= 1'b1;

      if (ls) begin
        disp_bank_reg <= ~disp_bank_reg;
        // Running product next_line*H_ACTIVE, valid as long as every line sees its ls.
        if (next_line == '0) begin
          line_base_reg <= '0;
        end else begin
          line_base_reg <= line_base_reg + ADDR_W'(H_ACTIVE);
        end
      end

      if (start) begin
        x_issue_reg <= '0;
        lb_bank_reg <= disp_bank_reg;
      end else if (issue) begin
        x_issue_reg <= x_issue_reg + 1'b1;
      end

      if (state_reg == ST_FETCH) begin
        share_cnt_reg <= slot ? '0 : share_cnt_reg + 1'b1;
      end

      if (state_reg == ST_DRAIN) begin
        drain_cnt_reg <= drain_cnt_reg + 1'b1;
      end else begin
        drain_cnt_reg <= '0;
      end

      if (abort) begin
        underrun_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge board_clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      mem_req_reg <= issue || wr_fire;
      mem_we_reg  <= wr_fire;
      if (wr_fire) begin
        mem_addr_reg  <= wr.wr_addr;
        mem_wdata_reg <= wr.wr_data;
      end else if (issue) begin
        mem_addr_reg  <= line_base_reg + ADDR_W'(x_issue_reg);
      end
    end
  end

  assign pipe_in.valid = issue;
  assign pipe_in.x     = x_issue_reg;

  vga_rd_return_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_rd_return_pipe (
    .clk     (board_clock),
    .rst_n   (reset_n),
    .flush   (abort),
    .in_tag  (pipe_in),
    .out_tag (pipe_out)
  );

  // Returns landing on an aborting line start belong to the abandoned line.
  assign lb_we    = pipe_out.valid && !abort;
  assign lb_addr  = pipe_out.x;
  assign lb_wdata = lb_we ? fb.mem_rdata : '0;
  assign lb_bank  = lb_bank_reg;

  assign fb.mem_req   = mem_req_reg;
  assign fb.mem_we    = mem_we_reg;
  assign fb.mem_addr  = mem_addr_reg;
  assign fb.mem_wdata = mem_wdata_reg;

  assign wr.wr_ready  = wr_ready_c;
  assign disp_bank    = disp_bank_reg;
  assign fetch_busy   = busy;
  assign underrun     = underrun_reg;

endmodule

// File: tb/tb_vga_line_fetch_ctrl.sv
// Directed bench for vga_line_fetch_ctrl: per-cycle bus log plus
// post-line analysis checked with immediate assertions.
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end end

module tb_vga_line_fetch_ctrl;
  import vga_line_fetch_ctrl_pkg::*;

  localparam int RD_LAT   = 2;
  localparam int WR_SHARE = 4;
  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 24;
  localparam int LOG_N    = 1100;

  logic              board_clock = 1'b0;
  logic              reset_n     = 1'b0;
  logic              pix_ce      = 1'b1;
  logic [11:0]       h_count     = 12'd1;
  logic [11:0]       v_count     = 12'd0;
  logic              lb_we, lb_bank, disp_bank, fetch_busy, underrun;
  logic [9:0]        lb_addr;
  logic [DATA_W-1:0] lb_wdata;

  vga_fb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) fb ();
  vga_wr_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wr ();

  vga_line_fetch_ctrl #(
    .RD_LAT   (RD_LAT),
    .WR_SHARE (WR_SHARE)
  ) dut (
    .board_clock (board_clock),
    .reset_n     (reset_n),
    .pix_ce      (pix_ce),
    .h_count     (h_count),
    .v_count     (v_count),
    .wr          (wr),
    .fb          (fb),
    .lb_we       (lb_we),
    .lb_bank     (lb_bank),
    .lb_addr     (lb_addr),
    .lb_wdata    (lb_wdata),
    .disp_bank   (disp_bank),
    .fetch_busy  (fetch_busy),
    .underrun    (underrun)
  );

  always #5 board_clock = ~board_clock;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return {5'b10101, a};
  endfunction

  // Framebuffer model: read data appears RD_LAT cycles after mem_req.
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  always @(posedge board_clock) begin
    rd_pipe[0] <= (fb.mem_req && !fb.mem_we) ? pat(fb.mem_addr) : '0;
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign fb.mem_rdata = rd_pipe[RD_LAT-1];

  logic              l_req [LOG_N];
  logic              l_we  [LOG_N];
  logic [ADDR_W-1:0] l_addr[LOG_N];
  logic [DATA_W-1:0] l_wd  [LOG_N];
  logic              l_lbwe[LOG_N];
  logic [9:0]        l_lba [LOG_N];
  logic [DATA_W-1:0] l_lbd [LOG_N];
  logic              l_lbb [LOG_N];
  logic              l_busy[LOG_N];
  int                log_n = 0;
  bit                log_en = 1'b0;

  always @(negedge board_clock) begin
    if (!log_en) begin
      log_n <= 0;
    end else if (log_n < LOG_N) begin
      l_req[log_n]  <= fb.mem_req;
      l_we[log_n]   <= fb.mem_we;
      l_addr[log_n] <= fb.mem_addr;
      l_wd[log_n]   <= fb.mem_wdata;
      l_lbwe[log_n] <= lb_we;
      l_lba[log_n]  <= lb_addr;
      l_lbd[log_n]  <= lb_wdata;
      l_lbb[log_n]  <= lb_bank;
      l_busy[log_n] <= fetch_busy;
      log_n         <= log_n + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  int a_n_rd, a_first, a_last, a_rd_err, a_n_lb, a_lb_err, a_last_lb;
  int a_busy_fall, a_busy_any, a_n_wr, a_wr_err, a_pat_err;
  logic [ADDR_W-1:0] a_first_addr;
  logic [84:0] all_out;

  task automatic analyze(input logic [ADDR_W-1:0] base, input logic bank,
                         input logic [ADDR_W-1:0] waddr, input logic [DATA_W-1:0] wdata);
    a_n_rd = 0; a_first = -1; a_last = -1; a_rd_err = 0; a_n_lb = 0; a_lb_err = 0;
    a_last_lb = -1; a_busy_fall = -1; a_busy_any = 0; a_n_wr = 0; a_wr_err = 0;
    a_pat_err = 0; a_first_addr = '1;
    for (int i = 0; i < log_n; i++) begin
      if (l_busy[i]) a_busy_any++;
      if (a_busy_fall < 0 && i > 0 && l_busy[i-1] && !l_busy[i]) a_busy_fall = i;
      if (l_req[i] && !l_we[i]) begin
        if (a_first < 0) begin a_first = i; a_first_addr = l_addr[i]; end
        if (l_addr[i] !== base + ADDR_W'(a_n_rd)) a_rd_err++;
        a_n_rd++;
        a_last = i;
      end
      if (l_lbwe[i]) begin
        if (l_lba[i] !== 10'(a_n_lb)) a_lb_err++;
        if (l_lbd[i] !== pat(base + ADDR_W'(l_lba[i]))) a_lb_err++;
        if (l_lbb[i] !== bank) a_lb_err++;
        a_n_lb++;
        a_last_lb = i;
      end
    end
    if (a_first >= 0) begin
      for (int i = a_first; i <= a_last; i++) begin
        if ((l_req[i] && l_we[i]) !== ((i - a_first) % WR_SHARE == WR_SHARE - 1)) a_pat_err++;
        if (l_req[i] && l_we[i]) begin
          a_n_wr++;
          if (l_addr[i] !== waddr || l_wd[i] !== wdata) a_wr_err++;
        end
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge board_clock);
    #1;
  endtask

  // One-cycle line start; the log restarts with the cycle after it.
  task automatic line_start(input logic [11:0] v);
    v_count = v;
    h_count = 12'd0;
    log_en  = 1'b0;
    @(posedge board_clock);
    #1;
    h_count = 12'd1;
    log_en  = 1'b1;
  endtask

  initial begin
    wr.wr_valid = 1'b0;
    wr.wr_addr  = '0;
    wr.wr_data  = '0;

    // Reset state
    #1;
    all_out = {fb.mem_req, fb.mem_we, fb.mem_addr, fb.mem_wdata, lb_we, lb_bank, lb_addr,
               lb_wdata, disp_bank, fetch_busy, underrun, wr.wr_ready};
    `CHK("reset_outputs", all_out, 85'd0)
    step(2);
    reset_n = 1'b1;
    step(2);

    // Writer request while idle
    wr.wr_valid = 1'b1;
    wr.wr_addr  = 19'h12345;
    wr.wr_data  = 24'hABCDEF;
    #1;
    `CHK("idle_wr_ready", wr.wr_ready, 1'b1)
    step(1);
    wr.wr_valid = 1'b0;
    `CHK("idle_wr_req", {fb.mem_req, fb.mem_we}, 2'b11)
    `CHK("idle_wr_addr", fb.mem_addr, 19'h12345)
    `CHK("idle_wr_data", fb.mem_wdata, 24'hABCDEF)
    `CHK("idle_wr_no_lbwe", lb_we, 1'b0)
    step(1);
    `CHK("idle_wr_single", fb.mem_req, 1'b0)
    `CHK("idle_wr_no_lbwe2", lb_we, 1'b0)

    // Plain fetch of line 1
    line_start(12'd0);
    `CHK("l1_disp_bank", disp_bank, 1'b1)
    `CHK("l1_busy", fetch_busy, 1'b1)
    step(700);
    analyze(19'd640, 1'b0, '0, '0);
    `CHK("l1_n_rd", a_n_rd, 640)
    `CHK("l1_first_addr", a_first_addr, 19'd640)
    `CHK("l1_first_req_idx", a_first, 1)
    `CHK("l1_rd_addr_err", a_rd_err, 0)
    `CHK("l1_n_lb", a_n_lb, 640)
    `CHK("l1_lb_err", a_lb_err, 0)
    `CHK("l1_n_wr", a_n_wr, 0)
    `CHK("l1_busy_drop", a_busy_fall - a_last, 2)
    `CHK("l1_last_return", a_last_lb - a_last, RD_LAT)

    // Fetch of line 2 with the writer always requesting
    wr.wr_valid = 1'b1;
    wr.wr_addr  = 19'h00777;
    wr.wr_data  = 24'h123456;
    line_start(12'd1);
    step(900);
    wr.wr_valid = 1'b0;
    analyze(19'd1280, 1'b1, 19'h00777, 24'h123456);
    `CHK("wr_n_rd", a_n_rd, 640)
    `CHK("wr_n_wr", a_n_wr, 213)
    `CHK("wr_window", a_last - a_first + 1, 853)
    `CHK("wr_pattern", a_pat_err, 0)
    `CHK("wr_payload", a_wr_err, 0)
    `CHK("wr_rd_addr_err", a_rd_err, 0)
    `CHK("wr_n_lb", a_n_lb, 640)
    `CHK("wr_lb_err", a_lb_err, 0)
    `CHK("wr_disp_bank", disp_bank, 1'b0)

    // Blanking lines 479..523: no fetch
    step(5);
    log_en = 1'b0;
    step(1);
    log_en = 1'b1;
    for (int v = 479; v <= 523; v++) begin
      v_count = 12'(v);
      h_count = 12'd0;
      step(1);
      h_count = 12'd1;
      step(3);
    end
    analyze('0, 1'b0, '0, '0);
    `CHK("blank_n_rd", a_n_rd, 0)
    `CHK("blank_busy", a_busy_any, 0)
    `CHK("blank_n_lb", a_n_lb, 0)
    `CHK("blank_disp_bank", disp_bank, 1'b1)

    // Frame wrap: line 0 fetched during v_count 524
    line_start(12'd524);
    step(700);
    analyze(19'd0, 1'b1, '0, '0);
    `CHK("wrap_first_addr", a_first_addr, 19'd0)
    `CHK("wrap_n_rd", a_n_rd, 640)
    `CHK("wrap_rd_addr_err", a_rd_err, 0)
    `CHK("wrap_n_lb", a_n_lb, 640)
    `CHK("wrap_lb_err", a_lb_err, 0)
    `CHK("wrap_disp_bank", disp_bank, 1'b0)
    `CHK("wrap_no_underrun", underrun, 1'b0)

    // Underrun: new line start 100 cycles into a fetch
    line_start(12'd0);
    step(99);
    `CHK("ur_before", underrun, 1'b0)
    `CHK("ur_busy_before", fetch_busy, 1'b1)
    line_start(12'd1);
    `CHK("ur_set", underrun, 1'b1)
    `CHK("ur_disp_bank", disp_bank, 1'b0)
    step(700);
    analyze(19'd1280, 1'b1, '0, '0);
    `CHK("ur_first_addr", a_first_addr, 19'd1280)
    `CHK("ur_n_rd", a_n_rd, 640)
    `CHK("ur_n_lb", a_n_lb, 640)
    `CHK("ur_lb_err", a_lb_err, 0)
    `CHK("ur_sticky", underrun, 1'b1)

    // Asynchronous reset in the middle of a fetch
    line_start(12'd0);
    step(50);
    reset_n = 1'b0;
    #1;
    all_out = {fb.mem_req, fb.mem_we, fb.mem_addr, fb.mem_wdata, lb_we, lb_bank, lb_addr,
               lb_wdata, disp_bank, fetch_busy, underrun, wr.wr_ready};
    `CHK("midrst_outputs", all_out, 85'd0)
    step(2);
    reset_n = 1'b1;
    step(3);
    `CHK("midrst_idle", fetch_busy, 1'b0)
    `CHK("midrst_wr_ready", wr.wr_ready, 1'b1)
    line_start(12'd0);
    step(700);
    analyze(19'd640, 1'b0, '0, '0);
    `CHK("resume_first_addr", a_first_addr, 19'd640)
    `CHK("resume_n_rd", a_n_rd, 640)
    `CHK("resume_n_lb", a_n_lb, 640)
    `CHK("resume_lb_err", a_lb_err, 0)
    `CHK("resume_disp_bank", disp_bank, 1'b1)

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`undef CHK
